// File: rtl/node_interface_pkg.sv
// Shared types and helpers for the NoC node endpoint: packet layout, field accessors, saturating add.
`ifndef NODES
`define NODES 16
`endif

package node_interface_pkg;

  localparam int NODES    = `NODES;
  localparam int ID_W     = $clog2(NODES);
  localparam int DATA_W   = 32;
  localparam int PKT_TS_W = 16;

  typedef logic [ID_W-1:0]     node_id_t;
  typedef logic [DATA_W-1:0]   payload_t;
  typedef logic [PKT_TS_W-1:0] stamp_t;

  typedef struct packed {
    node_id_t src;
    node_id_t dest;
    payload_t data;
    stamp_t   ts;
  } packet_t;

  function automatic packet_t pkt_make(node_id_t src, node_id_t dest, payload_t data, stamp_t ts);
    packet_t p;
    p.src  = src;
    p.dest = dest;
    p.data = data;
    p.ts   = ts;
    return p;
  endfunction

  function automatic node_id_t pkt_src(packet_t p);
    return p.src;
  endfunction

  function automatic node_id_t pkt_dest(packet_t p);
    return p.dest;
  endfunction

  function automatic payload_t pkt_data(packet_t p);
    return p.data;
  endfunction

  function automatic stamp_t pkt_ts(packet_t p);
    return p.ts;
  endfunction

  // Adds step to val and clamps at max; the 65-bit sum cannot overflow for any counter up to 64 bits.
  function automatic logic [63:0] sat_inc(logic [63:0] val, logic [63:0] step, logic [63:0] max);
    logic [64:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    return (sum > {1'b0, max}) ? max : sum[63:0];
  endfunction

endpackage

// File: rtl/node_interface_if.sv
// Bundle of core-side, network-side and statistics signals of one node endpoint.
interface node_interface_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = node_interface_pkg::PKT_TS_W,
  parameter int CNT_W      = 32,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
  import node_interface_pkg::*;

  logic             core_req_val;
  node_id_t         core_req_dest;
  payload_t         core_req_data;
  logic             core_req_rdy;

  packet_t          net_tx_data;
  logic             net_tx_val;
  logic             net_tx_en;
  packet_t          net_rx_data;
  logic             net_rx_val;

  logic             rx_val;
  node_id_t         rx_src;
  payload_t         rx_data;
  logic [TS_W-1:0]  rx_latency;
  logic [CNT_W-1:0] tx_count;
  logic [CNT_W-1:0] rx_count;
  logic [CNT_W-1:0] lat_sum;
  logic [TS_W-1:0]  lat_max;
  logic             err_misroute;
  logic [LVL_W-1:0] tx_level;

  modport slave (
    input  core_req_val, core_req_dest, core_req_data, net_tx_en, net_rx_data, net_rx_val,
    output core_req_rdy, net_tx_data, net_tx_val, rx_val, rx_src, rx_data, rx_latency,
           tx_count, rx_count, lat_sum, lat_max, err_misroute, tx_level
  );

  modport master (
    output core_req_val, core_req_dest, core_req_data, net_tx_en, net_rx_data, net_rx_val,
    input  core_req_rdy, net_tx_data, net_tx_val, rx_val, rx_src, rx_data, rx_latency,
           tx_count, rx_count, lat_sum, lat_max, err_misroute, tx_level
  );

endinterface

// File: rtl/node_tx_fifo.sv
// Synchronous show-ahead FIFO; a push is visible on head_o one cycle later.
// full_o is registered so the producer's ready never depends combinationally on pop_i.
module node_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/node_interface.sv
// Node endpoint of the mesh local port: buffers core requests for injection, delivers and profiles arrivals.
// TX head visible 1 cycle after push and held until the network enables it; RX is never stalled, 1-cycle delivery.
module node_interface
  import node_interface_pkg::*;
#(
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = PKT_TS_W,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              reset,
  node_interface_if.slave  node_if
);

  localparam int           LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam node_id_t     SELF_ID = node_id_t'(NODE_ID);
  localparam logic [63:0]  CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic             push, pop, full, empty;
  logic [LVL_W-1:0] level;
  packet_t          push_pkt, head_pkt;
  logic [TS_W-1:0]  arr_lat;

  logic [TS_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic             rx_val_q, rx_val_d;
  node_id_t         rx_src_q, rx_src_d;
  payload_t         rx_data_q, rx_data_d;
  logic [TS_W-1:0]  rx_latency_q, rx_latency_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;
  logic [CNT_W-1:0] lat_sum_q, lat_sum_d;
  logic [TS_W-1:0]  lat_max_q, lat_max_d;
  logic             err_q, err_d;

  assign push     = node_if.core_req_val && !full;
  assign pop      = !empty && node_if.net_tx_en;
  assign push_pkt = pkt_make(SELF_ID, node_if.core_req_dest, node_if.core_req_data, PKT_TS_W'(cyc_q));

  node_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(packet_t))
  ) u_tx_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (push),
    .push_dat_i (push_pkt),
    .pop_i      (pop),
    .head_o     (head_pkt),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level)
  );

  // Modular subtraction gives the right latency even when the counter has wrapped since injection.
  assign arr_lat = cyc_q - TS_W'(pkt_ts(node_if.net_rx_data));

  always_comb begin
    cyc_d        = cyc_q + TS_W'(1);
    tx_count_d   = tx_count_q;
    rx_val_d     = node_if.net_rx_val;
    rx_src_d     = rx_src_q;
    rx_data_d    = rx_data_q;
    rx_latency_d = rx_latency_q;
    rx_count_d   = rx_count_q;
    lat_sum_d    = lat_sum_q;
    lat_max_d    = lat_max_q;
    err_d        = err_q;
    if (pop) begin
      tx_count_d = CNT_W'(sat_inc(64'(tx_count_q), 64'd1, CNT_MAX));
    end
    if (node_if.net_rx_val) begin
      rx_src_d     = pkt_src(node_if.net_rx_data);
      rx_data_d    = pkt_data(node_if.net_rx_data);
      rx_latency_d = arr_lat;
      rx_count_d   = CNT_W'(sat_inc(64'(rx_count_q), 64'd1, CNT_MAX));
      lat_sum_d    = CNT_W'(sat_inc(64'(lat_sum_q), 64'(arr_lat), CNT_MAX));
      lat_max_d    = (arr_lat > lat_max_q) ? arr_lat : lat_max_q;
      if (pkt_dest(node_if.net_rx_data) != SELF_ID) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q        <= '0;
      tx_count_q   <= '0;
      rx_val_q     <= 1'b0;
      rx_src_q     <= '0;
      rx_data_q    <= '0;
      rx_latency_q <= '0;
      rx_count_q   <= '0;
      lat_sum_q    <= '0;
      lat_max_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      cyc_q        <= cyc_d;
      tx_count_q   <= tx_count_d;
      rx_val_q     <= rx_val_d;
      rx_src_q     <= rx_src_d;
      rx_data_q    <= rx_data_d;
      rx_latency_q <= rx_latency_d;
      rx_count_q   <= rx_count_d;
      lat_sum_q    <= lat_sum_d;
      lat_max_q    <= lat_max_d;
      err_q        <= err_d;
    end
  end

  assign node_if.core_req_rdy = !full;
  assign node_if.net_tx_val   = !empty;
  assign node_if.net_tx_data  = head_pkt;
  assign node_if.tx_level     = level;
  assign node_if.rx_val       = rx_val_q;
  assign node_if.rx_src       = rx_src_q;
  assign node_if.rx_data      = rx_data_q;
  assign node_if.rx_latency   = rx_latency_q;
  assign node_if.tx_count     = tx_count_q;
  assign node_if.rx_count     = rx_count_q;
  assign node_if.lat_sum      = lat_sum_q;
  assign node_if.lat_max      = lat_max_q;
  assign node_if.err_misroute = err_q;

endmodule
